uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Synthesizable UART receiver with an 8-entry receive FIFO; consumes the serial stream driven on ser_tx by the management core.
- Use 1: serial-sink checker in the DV benches (deserialized bytes, data + errors, instead of per-bit `$display`).
- Use 2: the core's loopback receive path.
- Format is fixed 8N1, LSB first, idle high; bit period set at runtime.

Parameters:
- DIV_WIDTH, 16, width of the clks_per_bit input.
- FIFO_DEPTH, 8, receive FIFO entries (power of two, ≥2).
- CNT_WIDTH, 8, width of the framing-error counter (saturating).

Ports:
- core_clk  input  1  sole clock.
- core_rst  input  1  synchronous reset, active-high.
- ser_rx  input  1  asynchronous serial input, idle high.
- clks_per_bit  input  DIV_WIDTH  core_clk cycles per bit. Legal ≥ 4; values < 4 are treated as 4. Sampled only at start-bit detect.
- rx_enable  input  1  0 = receiver held in IDLE, ser_rx ignored.
- rx_data  output  8  FIFO head byte.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  pop strobe; pops when rx_valid && rx_ready.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky: byte dropped because FIFO was full.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- frame_err_cnt  output  CNT_WIDTH  saturating framing-error count.
- err_clear  input  1  clears overflow and frame_err_cnt.

Behaviour:
- Reset values:
  - rx_valid=0, rx_data=0, fifo_level=0, overflow=0, frame_err=0, frame_err_cnt=0.
  - FSM=IDLE; synchronizer flops=1.
- ser_rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. Detection latency is 2 cycles.
- Divisor latch: at start detect, div = max(clks_per_bit, 4). Later changes do not affect the current frame.
- Bit counter counts down from div-1. "Mid-bit" = the cycle the counter reaches 0.
- FSM:
  - IDLE: on rx_enable && rx_s==0 (falling edge after idle), load half = div>>1 → START.
  - START: at half-period, re-sample. rx_s==0 → DATA, bit_idx=0, counter reloaded to div-1. rx_s==1 → glitch, return to IDLE, nothing recorded.
  - DATA: at each mid-bit, shift rx_s into shreg[bit_idx] (LSB first). After bit_idx=7 → STOP.
  - STOP: at mid-bit:
    - rx_s==1: push shreg into FIFO in the same cycle; the byte is visible on rx_valid/rx_data the next cycle.
    - rx_s==0: discard the byte, pulse frame_err for 1 cycle, increment frame_err_cnt (saturating at all-ones).
    - Either case → IDLE. The next start bit may be detected from the following cycle; no wait for full stop-bit end.
- rx_enable deasserted mid-frame: abort to IDLE next cycle, partial byte discarded, no error flagged.
- FIFO:
  - Circular buffer with wrap-around read/write pointers, one extra bit for the full/empty distinction.
  - rx_data is combinational from the head entry; it is 0 when empty.
  - Push while full (no simultaneous pop): byte dropped, overflow set. FIFO contents are unchanged.
  - Simultaneous push and pop when full: both occur, level unchanged, no overflow.
  - Simultaneous push and pop when empty: level goes 0→1.
  - Pop when empty: ignored.
- err_clear: clears overflow and frame_err_cnt next cycle. If an event coincides with err_clear, the event wins: overflow set, counter = 1.
- core_rst mid-frame: all state returns to reset values next edge; FIFO is emptied.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Constants: UART_DATA_BITS=8, UART_MIN_DIV=4.
- One sub-module: uart_rx_sync_fifo (parameterized depth/width, push/pop, level, full/empty).
- Synchronizer and FSM stay in the top module.

Test Plan:
1. clks_per_bit=16; send 0xA5, 0x3C, 0xFF → rx_valid rises 1 cycle after each stop mid-bit; bytes A5, 3C, FF pop in order; frame_err_cnt=0.
2. clks_per_bit=16; 0x55 with stop bit forced low → no push; frame_err pulses once; frame_err_cnt=1. A following 0x12 is received correctly.
3. rx_ready=0; send 9 bytes 0x00–0x08 → fifo_level=8, overflow=1, FIFO holds 0x00–0x07. err_clear → overflow=0, contents intact.
4. Low glitch on ser_rx of 5 cycles at clks_per_bit=16 → START rejects it, no byte, no error. Also at clks_per_bit=2: 0x81 received at an effective div of 4.
5. Reset mid-frame after 4 data bits → all outputs at reset values. Next full frame 0xC3 received correctly.
6. FIFO at 8 entries; pop and stop-bit push in the same cycle → level stays 8, overflow=0. Then 255+2 framing errors → frame_err_cnt saturates at 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: receiver FSM states and fixed 8N1 frame constants.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-byte stream: head byte, non-empty flag, pop strobe and occupancy.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [uart_pkg::UART_DATA_BITS-1:0] rx_data;
  logic                                rx_valid;
  logic                                rx_ready;
  logic [$clog2(FIFO_DEPTH):0]         fifo_level;

  modport master (output rx_data, rx_valid, fifo_level, input rx_ready);
  modport slave  (input rx_data, rx_valid, fifo_level, output rx_ready);
endinterface

// File: rtl/uart_rx_sync_fifo.sv
// Circular FIFO with wrap-bit pointers; write lands next cycle, head is combinational (0 when empty).
// A write while full is dropped (wr_drop) unless a read frees the slot in the same cycle.
module uart_rx_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   core_clk,
  input  logic                   core_rst,
  input  logic                   wr_vld,
  input  logic [WIDTH-1:0]       wr_dat,
  output logic                   wr_drop,
  input  logic                   rd_rdy,
  output logic                   rd_vld,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, do_wr, do_rd;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_rdy && !empty;
  assign do_wr   = wr_vld && (!full || do_rd);
  assign wr_drop = wr_vld && !do_wr;
  assign rd_vld  = !empty;
  assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver into a receive FIFO; byte visible one cycle after the stop-bit mid-sample.
// No backpressure on the line: a full FIFO drops the byte and sets sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 core_clk,
  input  logic                 core_rst,
  input  logic                 ser_rx,
  input  logic [DIV_WIDTH-1:0] clks_per_bit,
  input  logic                 rx_enable,
  uart_rx_fifo_if.master       rx_if,
  output logic                 overflow,
  output logic                 frame_err,
  output logic [CNT_WIDTH-1:0] frame_err_cnt,
  input  logic                 err_clear
);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  logic                        rx_meta, rx_s;
  uart_state_e                 state, state_nxt;
  logic [DIV_WIDTH-1:0]        cnt, cnt_nxt, div_q, div_nxt, div_in;
  logic [IDX_W-1:0]            bit_idx, bit_idx_nxt;
  logic [UART_DATA_BITS-1:0]   shreg, shreg_nxt, head_dat;
  logic                        push, ferr, drop, head_vld;
  logic [$clog2(FIFO_DEPTH):0] level;

  assign div_in = (clks_per_bit < DIV_WIDTH'(UART_MIN_DIV)) ? DIV_WIDTH'(UART_MIN_DIV)
                                                            : clks_per_bit;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= DIV_WIDTH'(UART_MIN_DIV);
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= ser_rx;
      rx_s    <= rx_meta;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div_q   <= div_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    div_nxt     = div_q;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    push        = 1'b0;
    ferr        = 1'b0;
    if (state == IDLE) begin
      // Divisor is frozen here so runtime changes only affect the next frame.
      if (rx_enable && !rx_s) begin
        div_nxt   = div_in;
        cnt_nxt   = div_in >> 1;
        state_nxt = START;
      end
    end else if (!rx_enable) begin
      state_nxt = IDLE;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - DIV_WIDTH'(1);
    end else begin
      cnt_nxt = div_q - DIV_WIDTH'(1);
      unique case (state)
        START: begin
          if (!rx_s) begin
            bit_idx_nxt = '0;
            state_nxt   = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
        DATA: begin
          shreg_nxt[bit_idx] = rx_s;
          if (bit_idx == IDX_W'(UART_DATA_BITS - 1)) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + 1'b1;
        end
        STOP: begin
          push      = rx_s;
          ferr      = !rx_s;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A coinciding error event outranks err_clear.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      overflow      <= 1'b0;
      frame_err     <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      frame_err <= ferr;
      if (err_clear) overflow <= drop;
      else if (drop) overflow <= 1'b1;
      if (err_clear) frame_err_cnt <= ferr ? CNT_WIDTH'(1) : '0;
      else if (ferr && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 1'b1;
    end
  end

  uart_rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .wr_vld   (push),
    .wr_dat   (shreg),
    .wr_drop  (drop),
    .rd_rdy   (rx_if.rx_ready),
    .rd_vld   (head_vld),
    .rd_dat   (head_dat),
    .level    (level)
  );

  assign rx_if.rx_valid   = head_vld;
  assign rx_if.rx_data    = head_dat;
  assign rx_if.fifo_level = level;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, checked against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b1;
  logic        ser_rx = 1'b1;
  logic        rx_enable = 1'b1;
  logic        err_clear = 1'b0;
  logic [15:0] clks_per_bit = 16'd16;
  logic        overflow, frame_err;
  logic [7:0]  frame_err_cnt;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rx_if();

  uart_rx_fifo #(.DIV_WIDTH(16), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .core_clk      (core_clk),
    .core_rst      (core_rst),
    .ser_rx        (ser_rx),
    .clks_per_bit  (clks_per_bit),
    .rx_enable     (rx_enable),
    .rx_if         (rx_if),
    .overflow      (overflow),
    .frame_err     (frame_err),
    .frame_err_cnt (frame_err_cnt),
    .err_clear     (err_clear)
  );

  always #5 core_clk = ~core_clk;

  logic [7:0] model_q[$];
  bit         model_ovf;
  int         model_cnt;
  int         vectors, miscompares;
  int         g_pop_at = -1, g_clr_at = -1, g_dis_at = -1, g_scr_at = -1;
  bit         g_scramble;
  int         cur_t, up_t, ferr_n, ferr_t, lvl_prev;

  // Edge index (counted from the start-bit launch) at which a byte lands: 2 sync + detect + half + 9 bits + 1.
  function automatic int exp_t(input int cpb);
    int d;
    d = (cpb < 4) ? 4 : cpb;
    return 4 + d / 2 + 9 * d;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop, input bit popped);
    if (popped) model_q.delete(0);
    if (!stop) model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endfunction

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic step();
    cur_t++;
    rx_if.rx_ready = (cur_t == g_pop_at);
    err_clear = (cur_t == g_clr_at);
    if (cur_t == g_dis_at) rx_enable = 1'b0;
    if (cur_t == g_scr_at) clks_per_bit = 16'($urandom_range(1, 60));
    tick();
    if (int'(rx_if.fifo_level) > lvl_prev && up_t < 0) up_t = cur_t;
    lvl_prev = int'(rx_if.fifo_level);
    if (frame_err) begin
      ferr_n++;
      ferr_t = cur_t;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int cpb, input int nbits);
    int d;
    logic [9:0] bits;
    d = (cpb < 4) ? 4 : cpb;
    bits = {stop, b, 1'b0};
    clks_per_bit = 16'(cpb);
    g_scr_at = g_scramble ? 2 * d : -1;
    cur_t = 0; up_t = -1; ferr_n = 0; ferr_t = -1;
    lvl_prev = int'(rx_if.fifo_level);
    for (int i = 0; i < nbits; i++) begin
      ser_rx = bits[i];
      if (i == 9) clks_per_bit = 16'(cpb);
      repeat (d) step();
    end
    if (nbits == 10) begin
      ser_rx = 1'b1;
      repeat (2 * d) step();
    end
    g_pop_at = -1; g_clr_at = -1; g_dis_at = -1; g_scr_at = -1; g_scramble = 1'b0;
    rx_if.rx_ready = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (model_q.size() > 0) begin
      vectors++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== model_q[0]) begin
        miscompares++;
        $display("FAIL %s_pop: got valid=%b data=%h, expected valid=1 data=%h", tag, rx_if.rx_valid, rx_if.rx_data, model_q[0]);
      end
      rx_if.rx_ready = 1'b1;
      tick();
      rx_if.rx_ready = 1'b0;
      model_q.delete(0);
    end
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
    vectors++;
    if (rx_if.fifo_level !== 4'd0 || rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL %s_empty: got level=%0d valid=%b data=%h, expected 0/0/00", tag, rx_if.fifo_level, rx_if.rx_valid, rx_if.rx_data);
    end
  endtask

  task automatic test_reset();
    core_rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 || rx_if.fifo_level !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_fifo: got valid=%b data=%h level=%0d, expected 0/00/0", rx_if.rx_valid, rx_if.rx_data, rx_if.fifo_level);
    end
    vectors++;
    if (overflow !== 1'b0 || frame_err !== 1'b0 || frame_err_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_err: got ovf=%b ferr=%b cnt=%0d, expected 0/0/0", overflow, frame_err, frame_err_cnt);
    end
    core_rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    logic [7:0] pat [3];
    pat = '{8'hA5, 8'h3C, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      send_frame(pat[i], 1'b1, 16, 10);
      model_frame(pat[i], 1'b1, 1'b0);
      vectors++;
      if (up_t !== exp_t(16)) begin
        miscompares++;
        $display("FAIL basic_push_time: got edge %0d, expected %0d", up_t, exp_t(16));
      end
    end
    vectors++;
    if (frame_err_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL basic_cnt: got %0d, expected 0", frame_err_cnt);
    end
    drain("basic");
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 16, 10);
    model_frame(8'h55, 1'b0, 1'b0);
    vectors++;
    if (ferr_n !== 1 || ferr_t !== exp_t(16)) begin
      miscompares++;
      $display("FAIL ferr_pulse: got %0d pulses at edge %0d, expected 1 at %0d", ferr_n, ferr_t, exp_t(16));
    end
    vectors++;
    if (rx_if.fifo_level !== 4'd0 || frame_err_cnt !== 8'(model_cnt)) begin
      miscompares++;
      $display("FAIL ferr_state: got level=%0d cnt=%0d, expected 0/%0d", rx_if.fifo_level, frame_err_cnt, model_cnt);
    end
    send_frame(8'h12, 1'b1, 16, 10);
    model_frame(8'h12, 1'b1, 1'b0);
    drain("ferr_next");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, 8, 10);
      model_frame(8'(i), 1'b1, 1'b0);
    end
    vectors++;
    if (rx_if.fifo_level !== 4'd8 || overflow !== model_ovf) begin
      miscompares++;
      $display("FAIL ovf_set: got level=%0d ovf=%b, expected 8/%b", rx_if.fifo_level, overflow, model_ovf);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    model_ovf = 1'b0;
    model_cnt = 0;
    vectors++;
    if (overflow !== 1'b0 || frame_err_cnt !== 8'h00 || rx_if.fifo_level !== 4'd8) begin
      miscompares++;
      $display("FAIL ovf_clear: got ovf=%b cnt=%0d level=%0d, expected 0/0/8", overflow, frame_err_cnt, rx_if.fifo_level);
    end
    drain("ovf");
  endtask

  task automatic test_glitch();
    int fe;
    fe = 0;
    clks_per_bit = 16'd16;
    ser_rx = 1'b0;
    repeat (5) tick();
    ser_rx = 1'b1;
    repeat (40) begin
      tick();
      if (frame_err) fe++;
    end
    vectors++;
    if (rx_if.fifo_level !== 4'd0 || fe !== 0 || frame_err_cnt !== 8'(model_cnt)) begin
      miscompares++;
      $display("FAIL glitch: got level=%0d ferr=%0d cnt=%0d, expected 0/0/%0d", rx_if.fifo_level, fe, frame_err_cnt, model_cnt);
    end
    send_frame(8'h81, 1'b1, 2, 10);
    model_frame(8'h81, 1'b1, 1'b0);
    vectors++;
    if (up_t !== exp_t(2)) begin
      miscompares++;
      $display("FAIL mindiv_push_time: got edge %0d, expected %0d", up_t, exp_t(2));
    end
    drain("mindiv");
  endtask

  task automatic test_reset_mid();
    send_frame(8'h77, 1'b1, 16, 10);
    model_frame(8'h77, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 16, 10);
    model_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'h3E, 1'b1, 16, 5);
    ser_rx = 1'b1;
    core_rst = 1'b1;
    tick();
    model_q.delete();
    model_cnt = 0;
    model_ovf = 1'b0;
    vectors++;
    if (rx_if.fifo_level !== 4'd0 || rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 ||
        overflow !== 1'b0 || frame_err !== 1'b0 || frame_err_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset: got level=%0d valid=%b data=%h ovf=%b ferr=%b cnt=%0d, expected all 0",
               rx_if.fifo_level, rx_if.rx_valid, rx_if.rx_data, overflow, frame_err, frame_err_cnt);
    end
    core_rst = 1'b0;
    repeat (4) tick();
    send_frame(8'hC3, 1'b1, 16, 10);
    model_frame(8'hC3, 1'b1, 1'b0);
    vectors++;
    if (up_t !== exp_t(16)) begin
      miscompares++;
      $display("FAIL midreset_push_time: got edge %0d, expected %0d", up_t, exp_t(16));
    end
    drain("midreset");
  endtask

  task automatic test_enable_abort();
    g_dis_at = 3 * 16 + 5;
    send_frame(8'h5A, 1'b1, 16, 10);
    vectors++;
    if (up_t !== -1 || ferr_n !== 0 || rx_if.fifo_level !== 4'd0) begin
      miscompares++;
      $display("FAIL abort: got push_edge=%0d ferr=%0d level=%0d, expected -1/0/0", up_t, ferr_n, rx_if.fifo_level);
    end
    rx_enable = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_full_pop_push();
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 8, 10);
      model_frame(b, 1'b1, 1'b0);
    end
    vectors++;
    if (rx_if.fifo_level !== 4'd8 || rx_if.rx_data !== model_q[0]) begin
      miscompares++;
      $display("FAIL fill: got level=%0d head=%h, expected 8/%h", rx_if.fifo_level, rx_if.rx_data, model_q[0]);
    end
    b = 8'($urandom);
    g_pop_at = exp_t(8);
    send_frame(b, 1'b1, 8, 10);
    model_frame(b, 1'b1, 1'b1);
    vectors++;
    if (rx_if.fifo_level !== 4'd8 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL poppush_full: got level=%0d ovf=%b, expected 8/0", rx_if.fifo_level, overflow);
    end
    drain("poppush");
  endtask

  task automatic test_clear_coincide();
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      send_frame(8'($urandom), 1'b0, 4, 10);
      model_frame(8'h00, 1'b0, 1'b0);
    end
    vectors++;
    if (frame_err_cnt !== 8'(model_cnt)) begin
      miscompares++;
      $display("FAIL cnt_two: got %0d, expected %0d", frame_err_cnt, model_cnt);
    end
    g_clr_at = exp_t(4);
    send_frame(8'($urandom), 1'b0, 4, 10);
    model_ovf = 1'b0;
    model_cnt = 0;
    model_frame(8'h00, 1'b0, 1'b0);
    vectors++;
    if (frame_err_cnt !== 8'(model_cnt)) begin
      miscompares++;
      $display("FAIL cnt_clear_event: got %0d, expected %0d", frame_err_cnt, model_cnt);
    end
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 4, 10);
      model_frame(b, 1'b1, 1'b0);
    end
    g_clr_at = exp_t(4);
    send_frame(8'hEE, 1'b1, 4, 10);
    model_ovf = 1'b0;
    model_cnt = 0;
    model_frame(8'hEE, 1'b1, 1'b0);
    vectors++;
    if (overflow !== model_ovf || frame_err_cnt !== 8'(model_cnt)) begin
      miscompares++;
      $display("FAIL ovf_clear_event: got ovf=%b cnt=%0d, expected %b/%0d", overflow, frame_err_cnt, model_ovf, model_cnt);
    end
    drain("coincide");
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    model_ovf = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_saturate();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 257; i++) begin
      send_frame(8'($urandom), 1'b0, 4, 10);
      model_frame(8'h00, 1'b0, 1'b0);
      pulses += ferr_n;
      if (i == 254) begin
        vectors++;
        if (frame_err_cnt !== 8'(model_cnt)) begin
          miscompares++;
          $display("FAIL sat_255: got %0d, expected %0d", frame_err_cnt, model_cnt);
        end
      end
    end
    vectors++;
    if (frame_err_cnt !== 8'(model_cnt) || pulses !== 257) begin
      miscompares++;
      $display("FAIL sat_hold: got cnt=%0d pulses=%0d, expected %0d/257", frame_err_cnt, pulses, model_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    bit         stop, was_full;
    int         cpb;
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      cpb = $urandom_range(1, 20);
      was_full = (model_q.size() == DEPTH);
      g_scramble = 1'b1;
      send_frame(b, stop, cpb, 10);
      model_frame(b, stop, 1'b0);
      vectors++;
      if (rx_if.fifo_level !== 4'(model_q.size()) || frame_err_cnt !== 8'(model_cnt) ||
          ferr_n !== (stop ? 0 : 1) || up_t !== ((stop && !was_full) ? exp_t(cpb) : -1)) begin
        miscompares++;
        $display("FAIL rand_frame%0d: got level=%0d cnt=%0d ferr=%0d push_edge=%0d, expected %0d/%0d/%0d/%0d",
                 i, rx_if.fifo_level, frame_err_cnt, ferr_n, up_t, model_q.size(), model_cnt,
                 stop ? 0 : 1, (stop && !was_full) ? exp_t(cpb) : -1);
      end
      if ($urandom_range(0, 2) == 0 && model_q.size() > 0) begin
        vectors++;
        if (rx_if.rx_data !== model_q[0]) begin
          miscompares++;
          $display("FAIL rand_pop%0d: got %h, expected %h", i, rx_if.rx_data, model_q[0]);
        end
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        model_q.delete(0);
      end
    end
    vectors++;
    if (overflow !== model_ovf) begin
      miscompares++;
      $display("FAIL rand_ovf: got %b, expected %b", overflow, model_ovf);
    end
    drain("rand");
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    vectors = 0;
    miscompares = 0;
    model_ovf = 1'b0;
    model_cnt = 0;
    test_reset();
    test_basic();
    test_frame_err();
    test_overflow();
    test_glitch();
    test_reset_mid();
    test_enable_abort();
    test_full_pop_push();
    test_clear_coincide();
    test_saturate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
